// File: rtl/stream_mux_rr.sv
// N-way valid/ready stream multiplexer with a registered output stage.
// Arbitration is round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
module stream_mux_rr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 0,
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] chan [N];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] gsel;
    logic [SEL_W-1:0] idx;
    logic [N-1:0]     grant;
    logic             found;
    logic             load;
    int unsigned      pos;

    for (genvar i = 0; i < N; i++) begin : g_chan
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    // First valid channel in search order starting at ptr (or at 0 in priority mode).
    always_comb begin
        grant = '0;
        gsel  = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = k + ((MODE == 0) ? 32'(ptr) : 32'd0);
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = SEL_W'(pos);
            if (!found && in_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gsel       = idx;
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign in_ready = grant & {N{load}} & {N{rst_n}};
    assign ptr_nxt  = (32'(gsel) == N - 1) ? '0 : gsel + SEL_W'(1);

    // Output register and round-robin pointer; an empty load clears only the valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= chan[gsel];
                out_sel  <= gsel;
                if (MODE == 0) begin
                    ptr <= ptr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench: round-robin and fixed-priority instances driven with the same
// stimulus, each checked against a queue-based reference model.
module tb_stream_mux_rr;

    typedef logic [33:0] ent_t;   // {sel[1:0], data[31:0]}

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [3:0]   rdy [2];
    logic         ov  [2];
    logic [31:0]  od  [2];
    logic [1:0]   os  [2];

    ent_t         q [2][$];
    int           mp [2]     = '{0, 0};
    logic [31:0]  last_d [2] = '{32'd0, 32'd0};
    logic [1:0]   last_s [2] = '{2'd0, 2'd0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(32), .N(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(32), .N(4), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input int m, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s mode%0d t=%0t got %h exp %h", name, m, $time, got, exp);
        end
    endtask

    // Channel the arbitration rule selects, or -1 when nothing is valid.
    function automatic int pick(input logic [3:0] v, input int mode, input int p);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (mode == 1) ? k : (p + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference model: predict in_ready and the word accepted at the coming edge.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int         g;
            bit         full;
            bit         ld;
            logic [3:0] er;
            g    = rst_n ? pick(in_valid, m, mp[m]) : -1;
            full = (q[m].size() != 0);
            ld   = !full || out_ready;
            er   = (ld && g >= 0) ? 4'(1 << g) : 4'd0;
            chk("in_ready", m, 64'(rdy[m]), 64'(er));
            chk("out_valid", m, 64'(ov[m]), 64'(full));
            if (!full) begin
                chk("hold_data", m, 64'(od[m]), 64'(last_d[m]));
                chk("hold_sel", m, 64'(os[m]), 64'(last_s[m]));
            end
            if (!rst_n) begin
                mp[m]     = 0;
                last_d[m] = 32'd0;
                last_s[m] = 2'd0;
            end else if (ld && g >= 0) begin
                last_d[m] = in_data[g*32 +: 32];
                last_s[m] = 2'(g);
                q[m].push_back({last_s[m], last_d[m]});
                if (m == 0) mp[m] = (g + 1) % 4;
            end
        end
    end

    // Monitor: compare every presented word, retire it on the output handshake.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                q[m].delete();
            end else if (ov[m]) begin
                if (q[m].size() == 0) begin
                    chk("unexpected_word", m, 64'(1), 64'(0));
                end else begin
                    ent_t e;
                    e = q[m][0];
                    chk("out_data", m, 64'(od[m]), 64'(e[31:0]));
                    chk("out_sel", m, 64'(os[m]), 64'(e[33:32]));
                    if (out_ready) void'(q[m].pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA000_0000 | 32'(i);
        cyc(3);

        // Release: seven grants leave the round-robin pointer at 3.
        rst_n = 1'b1;
        cyc(7);

        // Wrap and skip with only channels 1 and 3 valid.
        in_valid = 4'b1010;
        cyc(3);

        // Backpressure with changing input data behind a held word.
        in_valid = 4'b0001;
        in_data[31:0] = 32'h1234_5678;
        cyc(1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data[31:0] = $urandom;
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(1);

        // Fixed priority with 2 and 3 valid, then channel 0 joins.
        in_valid = 4'b1100;
        cyc(4);
        in_valid = 4'b1101;
        cyc(2);

        // Empty drain after one word from channel 1, then all valid.
        in_valid = 4'b0010;
        cyc(1);
        in_valid = 4'b0000;
        cyc(3);
        in_valid = 4'b1111;
        cyc(1);
        in_valid = 4'b0000;
        cyc(1);

        // Randomized traffic with sporadic backpressure and resets.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            cyc(1);
        end

        rst_n     = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
